sap1_ram_arbiter: RTL and testbench
===================================

Name: sap1_ram_arbiter

Overview:
- Sequences and shares the SAP-1 16-word program/data RAM, built from two 16x4 active-low-strobe RAM chips forming an 8-bit word.
- Serves two requesters:
  - CPU port: read and write.
  - Loader port: write-only, fed by the front-panel programming switches.
- Generates properly phased address, data, n_ce and n_we for the RAM pair, with a req/ack handshake per port.
- Sits between the SAP-1 control sequencer, the programming panel logic and the RAM pair.

Parameters:
- ADDR_W, 4, address width (16 words).
- DATA_W, 8, word width (two 4-bit chips side by side).
- WE_PULSE, 1, number of cycles n_we is held low during a write; legal range 1..15.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- prog  in  1  1 = programming mode: CPU requests ignored; 0 = run mode: both ports eligible.
- cpu_req  in  1  CPU request; held high until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read; sampled at accept.
- cpu_addr  in  ADDR_W  CPU word address; sampled at accept.
- cpu_wdata  in  DATA_W  CPU write data; sampled at accept.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  DATA_W  read result; valid in the cpu_ack cycle, held until the next CPU read completes.
- ld_req  in  1  loader write request; held high until ld_ack.
- ld_addr  in  ADDR_W  loader address; sampled at accept.
- ld_wdata  in  DATA_W  loader data; sampled at accept.
- ld_ack  out  1  one-cycle completion pulse.
- busy  out  1  high in every non-IDLE state.
- ram_a  out  ADDR_W  RAM address, common to both chips.
- ram_d  out  DATA_W  RAM write data; bits [3:0] go to the low chip, [7:4] to the high chip.
- ram_n_ce  out  1  active-low chip enable to both chips.
- ram_n_we  out  1  active-low write enable to both chips.
- ram_q  in  DATA_W  RAM read data, concatenated from both chips.

Behaviour:
- Reset: state is IDLE. Outputs are ram_n_ce=1, ram_n_we=1, ram_a=0, ram_d=0, cpu_ack=0, ld_ack=0, cpu_rdata=0, busy=0.
  - Reset mid-transaction aborts it: the cycle after the reset edge shows reset values, and no ack is ever issued for the aborted request.
  - A request still high after reset is treated as new.
- All RAM-side outputs are registered and are driven from the address/data latched at accept. They are stable for the whole transaction regardless of requester input changes.
- States: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE.
- IDLE:
  - Drives ram_n_ce=1 and ram_n_we=1; ram_a and ram_d keep their last values.
  - Grant is decided on the rising edge:
    - ld_req=1 wins.
    - Otherwise cpu_req=1 and prog=0 wins.
    - Otherwise stay in IDLE.
  - Fixed priority, loader over CPU; no preemption of an in-flight transaction.
  - Grant latches the owner, addr, wdata and write flag (loader is always write).
  - Next state is RD for a CPU read, otherwise WR_SETUP.
- RD, 1 cycle:
  - ram_n_ce=0, ram_n_we=1.
  - ram_q is registered into a read buffer at the end of the cycle.
  - Next state is DONE.
- WR_SETUP, 1 cycle: ram_n_ce=0, ram_n_we=1, with address and data stable. Next state is WR_PULSE.
- WR_PULSE, WE_PULSE cycles: ram_n_ce=0, ram_n_we=0. A down-counter is loaded with WE_PULSE-1 on entry. Next state is WR_HOLD when the counter reaches 0.
- WR_HOLD, 1 cycle: ram_n_ce=0, ram_n_we=1, with address and data still stable. Next state is DONE.
  - Guarantee: n_we never falls or rises in the same cycle that address or data changes, or that n_ce changes.
- DONE, 1 cycle:
  - ram_n_ce=1, ram_n_we=1.
  - The owner's ack is 1; the other port's ack is 0.
  - For a CPU read, cpu_rdata is updated from the read buffer in this cycle.
  - Next state is IDLE.
- Latency from the request being seen high in IDLE to the ack cycle:
  - Read: 2 cycles.
  - Write: WE_PULSE+3 cycles.
  - Minimum back-to-back spacing is 1 IDLE cycle between transactions.
- Handshake:
  - The requester may drop req in the cycle after ack.
  - A req still high in the IDLE cycle after DONE is a new request and is re-arbitrated.
  - The bench must drop req on seeing ack to avoid a duplicate.
  - Changing addr, data or we while req is high and not yet granted is allowed; values are taken at grant.
- prog:
  - prog is evaluated only at grant. Toggling it mid-transaction does not abort the transaction.
  - A CPU request pending while prog=1 waits without an ack until prog=0.
- Simultaneous requests: the loader is served first and the CPU afterwards. The CPU waits as long as the loader keeps requesting back-to-back; this starvation is accepted.
- Address is ADDR_W bits with no arithmetic, so there is no wrap condition. All 16 locations are reachable, including 0 and 15.

Test Plan:
- Reset: hold rst 2 cycles with ld_req=1 -> ram_n_ce=1, ram_n_we=1, acks=0, busy=0. After release, the loader is accepted the next edge.
- Loader write, WE_PULSE=1: addr=4'hF, data=8'hA5 -> WR_SETUP/WR_PULSE/WR_HOLD seen as n_we 1,0,1 with n_ce=0 throughout and ram_a=F, ram_d=A5 stable. ld_ack arrives in cycle 4 after the request.
- CPU read after load, prog=0: addr=F -> RD has n_ce=0, n_we=1. cpu_ack arrives in cycle 2 with cpu_rdata=8'hA5. Read addr 0 after writing 8'h3C there -> 8'h3C.
- Contention: ld_req and cpu_req (read addr 0) rise in the same cycle -> loader write completes first, then one IDLE cycle, then the CPU read. Exactly one ack per port.
- prog gating: prog=1 with cpu_req=1 for 20 cycles -> no cpu_ack and RAM outputs stay idle. Drop prog to 0 -> the read completes 2 cycles later.
- Reset mid-write, WE_PULSE=4: assert rst during WR_PULSE -> next cycle n_we=1 and n_ce=1, no ld_ack. A later read shows the location is either unchanged or the new value, and the bench does not check which.

Source files
------------

// File: rtl/sap1_ram_arbiter.sv
// -----------------------------------------------------------------------------
// sap1_ram_arbiter
//
// Sequences and shares the SAP-1 16-word RAM (two 16x4 chips with active-low
// strobes forming one 8-bit word) between two requesters:
//   - the CPU port (read or write), eligible only when prog = 0
//   - the loader port (write only), fed by the front-panel switches
// The loader has fixed priority over the CPU. A granted transaction always
// runs to completion; only rst can cut it short.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   prog            1 = programming mode (CPU requests held off)
//   cpu_req/cpu_we/cpu_addr/cpu_wdata   CPU request, sampled at grant
//   cpu_ack         one-cycle completion pulse for the CPU
//   cpu_rdata       last CPU read result, valid from the cpu_ack cycle onward
//   ld_req/ld_addr/ld_wdata             loader write request, sampled at grant
//   ld_ack          one-cycle completion pulse for the loader
//   busy            high whenever the sequencer is not idle
//   ram_a/ram_d     registered RAM address and write data (both chips)
//   ram_n_ce/ram_n_we  registered active-low chip enable / write enable
//   ram_q           RAM read data, {high chip, low chip}
//
// Write timing: address/data and n_ce change together on entry to WR_SETUP,
// n_we falls one cycle later, rises one cycle before n_ce rises, so n_we
// never moves in the same cycle as address, data or n_ce.
// -----------------------------------------------------------------------------
module sap1_ram_arbiter #(
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 8,
    parameter int WE_PULSE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prog,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_ack,
    output logic              busy,
    output logic [ADDR_W-1:0] ram_a,
    output logic [DATA_W-1:0] ram_d,
    output logic              ram_n_ce,
    output logic              ram_n_we,
    input  logic [DATA_W-1:0] ram_q
);

    // Pulse counter is wide enough for the full 1..15 legal range.
    localparam int              CNT_W      = 4;
    localparam logic [CNT_W-1:0] CNT_ZERO  = 4'd0;
    localparam logic [CNT_W-1:0] CNT_ONE   = 4'd1;
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(WE_PULSE - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD       = 3'd1,
        ST_WR_SETUP = 3'd2,
        ST_WR_PULSE = 3'd3,
        ST_WR_HOLD  = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic                grant_ld_s;
    logic                grant_cpu_s;

    logic                owner_ld_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [ADDR_W-1:0]   ram_a_r;
    logic [DATA_W-1:0]   ram_d_r;
    logic [DATA_W-1:0]   cpu_rdata_r;

    logic                ram_n_ce_r;
    logic                ram_n_we_r;
    logic                cpu_ack_r;
    logic                ld_ack_r;
    logic                busy_r;

    logic                n_ce_nxt_s;
    logic                n_we_nxt_s;
    logic                cpu_ack_nxt_s;
    logic                ld_ack_nxt_s;
    logic                busy_nxt_s;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic and arbitration (loader beats CPU, prog gates CPU).
    always_comb begin
        state_nxt_s = state_r;
        grant_ld_s  = 1'b0;
        grant_cpu_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (ld_req) begin
                    grant_ld_s  = 1'b1;
                    state_nxt_s = ST_WR_SETUP;
                end else if (cpu_req && !prog) begin
                    grant_cpu_s = 1'b1;
                    state_nxt_s = cpu_we ? ST_WR_SETUP : ST_RD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RD:       state_nxt_s = ST_DONE;
            ST_WR_SETUP: state_nxt_s = ST_WR_PULSE;
            ST_WR_PULSE: begin
                if (cnt_r == CNT_ZERO) begin
                    state_nxt_s = ST_WR_HOLD;
                end else begin
                    state_nxt_s = ST_WR_PULSE;
                end
            end
            ST_WR_HOLD:  state_nxt_s = ST_DONE;
            ST_DONE:     state_nxt_s = ST_IDLE;
            default:     state_nxt_s = ST_IDLE;
        endcase
    end

    // Output decode from the next state, so the registered strobes line up
    // with the state they belong to.
    always_comb begin
        n_ce_nxt_s    = 1'b1;
        n_we_nxt_s    = 1'b1;
        cpu_ack_nxt_s = 1'b0;
        ld_ack_nxt_s  = 1'b0;
        busy_nxt_s    = (state_nxt_s != ST_IDLE);
        case (state_nxt_s)
            ST_IDLE: begin
                n_ce_nxt_s = 1'b1;
            end
            ST_RD, ST_WR_SETUP, ST_WR_HOLD: begin
                n_ce_nxt_s = 1'b0;
            end
            ST_WR_PULSE: begin
                n_ce_nxt_s = 1'b0;
                n_we_nxt_s = 1'b0;
            end
            ST_DONE: begin
                if (owner_ld_r) begin
                    ld_ack_nxt_s = 1'b1;
                end else begin
                    cpu_ack_nxt_s = 1'b1;
                end
            end
            default: begin
                n_ce_nxt_s = 1'b1;
            end
        endcase
    end

    // Registered control outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            ram_n_ce_r <= 1'b1;
            ram_n_we_r <= 1'b1;
            cpu_ack_r  <= 1'b0;
            ld_ack_r   <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            ram_n_ce_r <= n_ce_nxt_s;
            ram_n_we_r <= n_we_nxt_s;
            cpu_ack_r  <= cpu_ack_nxt_s;
            ld_ack_r   <= ld_ack_nxt_s;
            busy_r     <= busy_nxt_s;
        end
    end

    // Grant-time capture of owner/address/data, pulse counter, read buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_ld_r  <= 1'b0;
            cnt_r       <= CNT_ZERO;
            ram_a_r     <= {ADDR_W{1'b0}};
            ram_d_r     <= {DATA_W{1'b0}};
            cpu_rdata_r <= {DATA_W{1'b0}};
        end else begin
            if (grant_ld_s) begin
                owner_ld_r <= 1'b1;
                ram_a_r    <= ld_addr;
                ram_d_r    <= ld_wdata;
            end else if (grant_cpu_s) begin
                owner_ld_r <= 1'b0;
                ram_a_r    <= cpu_addr;
                ram_d_r    <= cpu_wdata;
            end

            // Loaded while in WR_SETUP so it holds WE_PULSE-1 on the first
            // WR_PULSE cycle; the pulse ends on the cycle it reads zero.
            if (state_r == ST_WR_SETUP) begin
                cnt_r <= PULSE_LAST;
            end else if ((state_r == ST_WR_PULSE) && (cnt_r != CNT_ZERO)) begin
                cnt_r <= cnt_r - CNT_ONE;
            end

            // Only CPU reads visit RD; the captured word is presented in DONE
            // and held until the next CPU read.
            if (state_r == ST_RD) begin
                cpu_rdata_r <= ram_q;
            end
        end
    end

    assign ram_a     = ram_a_r;
    assign ram_d     = ram_d_r;
    assign ram_n_ce  = ram_n_ce_r;
    assign ram_n_we  = ram_n_we_r;
    assign cpu_ack   = cpu_ack_r;
    assign ld_ack    = ld_ack_r;
    assign busy      = busy_r;
    assign cpu_rdata = cpu_rdata_r;

endmodule

// File: tb/tb_sap1_ram_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for sap1_ram_arbiter. Two instances are built: one with
// WE_PULSE=1 and one with WE_PULSE=4, each with its own behavioural RAM pair.
// Requests are steered to one instance at a time through 'sel'.
// -----------------------------------------------------------------------------
module tb_sap1_ram_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, prog, sel;
    logic       cpu_req, cpu_we, ld_req;
    logic [3:0] cpu_addr, ld_addr;
    logic [7:0] cpu_wdata, ld_wdata;

    logic       p1_cpu_req, p1_ld_req, p4_cpu_req, p4_ld_req;
    logic       p1_cpu_ack, p1_ld_ack, p1_busy, p1_n_ce, p1_n_we;
    logic       p4_cpu_ack, p4_ld_ack, p4_busy, p4_n_ce, p4_n_we;
    logic [3:0] p1_ram_a, p4_ram_a;
    logic [7:0] p1_ram_d, p4_ram_d, p1_ram_q, p4_ram_q, p1_rdata, p4_rdata;

    logic       o_cpu_ack, o_ld_ack, o_busy, o_n_ce, o_n_we;
    logic [3:0] o_ram_a;
    logic [7:0] o_ram_d, o_rdata;

    logic [7:0] mem1 [16];
    logic [7:0] mem4 [16];

    assign p1_cpu_req = cpu_req & ~sel;
    assign p1_ld_req  = ld_req  & ~sel;
    assign p4_cpu_req = cpu_req &  sel;
    assign p4_ld_req  = ld_req  &  sel;

    sap1_ram_arbiter #(.ADDR_W(4), .DATA_W(8), .WE_PULSE(1)) u_dut1 (
        .clk(clk), .rst(rst), .prog(prog),
        .cpu_req(p1_cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(p1_cpu_ack), .cpu_rdata(p1_rdata),
        .ld_req(p1_ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_ack(p1_ld_ack),
        .busy(p1_busy), .ram_a(p1_ram_a), .ram_d(p1_ram_d),
        .ram_n_ce(p1_n_ce), .ram_n_we(p1_n_we), .ram_q(p1_ram_q)
    );

    sap1_ram_arbiter #(.ADDR_W(4), .DATA_W(8), .WE_PULSE(4)) u_dut4 (
        .clk(clk), .rst(rst), .prog(prog),
        .cpu_req(p4_cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(p4_cpu_ack), .cpu_rdata(p4_rdata),
        .ld_req(p4_ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_ack(p4_ld_ack),
        .busy(p4_busy), .ram_a(p4_ram_a), .ram_d(p4_ram_d),
        .ram_n_ce(p4_n_ce), .ram_n_we(p4_n_we), .ram_q(p4_ram_q)
    );

    // RAM pair models: write while both strobes low, read only while selected.
    always @(posedge clk) begin
        if (!p1_n_ce && !p1_n_we) mem1[p1_ram_a] <= p1_ram_d;
        if (!p4_n_ce && !p4_n_we) mem4[p4_ram_a] <= p4_ram_d;
    end
    assign p1_ram_q = (!p1_n_ce && p1_n_we) ? mem1[p1_ram_a] : 8'h00;
    assign p4_ram_q = (!p4_n_ce && p4_n_we) ? mem4[p4_ram_a] : 8'h00;

    assign o_cpu_ack = sel ? p4_cpu_ack : p1_cpu_ack;
    assign o_ld_ack  = sel ? p4_ld_ack  : p1_ld_ack;
    assign o_busy    = sel ? p4_busy    : p1_busy;
    assign o_n_ce    = sel ? p4_n_ce    : p1_n_ce;
    assign o_n_we    = sel ? p4_n_we    : p1_n_we;
    assign o_ram_a   = sel ? p4_ram_a   : p1_ram_a;
    assign o_ram_d   = sel ? p4_ram_d   : p1_ram_d;
    assign o_rdata   = sel ? p4_rdata   : p1_rdata;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One complete transaction; expected latency is derived from wp.
    task automatic do_txn(input bit is_ld, input bit we, input logic [3:0] a,
                          input logic [7:0] d, input bit chk_rd,
                          input logic [7:0] exp_rd, input int wp);
        int   lat_exp, lat;
        bit   seq_ok, ad_ok, oth_ok, wr;
        logic exp_nwe;
        wr      = is_ld || we;
        lat_exp = wr ? wp + 3 : 2;
        lat = 0; seq_ok = 1'b1; ad_ok = 1'b1; oth_ok = 1'b1;
        if (is_ld) begin
            ld_addr = a; ld_wdata = d; ld_req = 1'b1;
        end else begin
            cpu_addr = a; cpu_wdata = d; cpu_we = we; cpu_req = 1'b1;
        end
        for (int k = 1; k <= 40 && lat == 0; k++) begin
            @(negedge clk);
            if ((is_ld ? o_cpu_ack : o_ld_ack) !== 1'b0) oth_ok = 1'b0;
            if ((is_ld ? o_ld_ack : o_cpu_ack) === 1'b1) begin
                lat = k;
                check("done_strobes", {29'd0, o_n_ce, o_n_we, o_busy}, 32'h7);
                if (is_ld) ld_req = 1'b0; else cpu_req = 1'b0;
            end else begin
                exp_nwe = wr ? !(k >= 2 && k <= wp + 1) : 1'b1;
                if (o_n_ce !== 1'b0 || o_n_we !== exp_nwe || o_busy !== 1'b1) seq_ok = 1'b0;
                if (o_ram_a !== a || (wr && o_ram_d !== d)) ad_ok = 1'b0;
            end
            // Scramble requester inputs after grant: RAM side must not follow.
            if (k == 1) begin
                if (is_ld) begin
                    ld_addr = ~a; ld_wdata = ~d;
                end else begin
                    cpu_addr = ~a; cpu_wdata = ~d; cpu_we = ~we;
                end
            end
        end
        if (lat == 0) begin
            if (is_ld) ld_req = 1'b0; else cpu_req = 1'b0;
        end
        check("latency", lat, lat_exp);
        check("strobe_seq", {31'd0, seq_ok}, 32'd1);
        check("addr_data_stable", {31'd0, ad_ok}, 32'd1);
        check("other_ack_quiet", {31'd0, oth_ok}, 32'd1);
        if (chk_rd) check("cpu_rdata", {24'd0, o_rdata}, {24'd0, exp_rd});
        @(negedge clk);
        check("ack_single_pulse", {29'd0, o_ld_ack, o_cpu_ack, o_busy}, 32'd0);
    endtask

    typedef struct {
        bit         is_ld;
        bit         we;
        logic [3:0] addr;
        logic [7:0] data;
        logic [7:0] exp_rd;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int   ld_at, cpu_at, ld_n, cpu_n, lat;
        bit   gap_ok, gate_ok, seen, quiet;

        // is_ld, we, addr, data, expected cpu_rdata after the transaction
        vecs[0] = '{1'b1, 1'b1, 4'h0, 8'h3C, 8'h00};
        vecs[1] = '{1'b0, 1'b0, 4'hF, 8'h00, 8'hA5};
        vecs[2] = '{1'b0, 1'b0, 4'h0, 8'h00, 8'h3C};
        vecs[3] = '{1'b0, 1'b1, 4'h7, 8'h5A, 8'h3C};
        vecs[4] = '{1'b0, 1'b0, 4'h7, 8'h00, 8'h5A};
        vecs[5] = '{1'b1, 1'b1, 4'h7, 8'hC3, 8'h5A};
        vecs[6] = '{1'b0, 1'b0, 4'h7, 8'h00, 8'hC3};
        vecs[7] = '{1'b0, 1'b0, 4'h0, 8'h00, 8'h3C};

        sel = 1'b0; prog = 1'b0; rst = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 4'h0; cpu_wdata = 8'h00;
        ld_req = 1'b1; ld_addr = 4'hF; ld_wdata = 8'hA5;

        // Reset held for two cycles with a loader request pending.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_strobes", {30'd0, o_n_ce, o_n_we}, 32'h3);
            check("rst_acks_busy", {21'd0, o_ld_ack, o_cpu_ack, o_busy, o_rdata}, 32'd0);
            check("rst_addr_data", {20'd0, o_ram_a, o_ram_d}, 32'd0);
        end
        rst = 1'b0;
        do_txn(1'b1, 1'b1, 4'hF, 8'hA5, 1'b1, 8'h00, 1);

        for (int i = 0; i < 8; i++) begin
            do_txn(vecs[i].is_ld, vecs[i].we, vecs[i].addr, vecs[i].data,
                   1'b1, vecs[i].exp_rd, 1);
        end

        // Contention: loader write and CPU read of the same word together.
        ld_addr = 4'h2; ld_wdata = 8'h77; ld_req = 1'b1;
        cpu_addr = 4'h2; cpu_we = 1'b0; cpu_req = 1'b1;
        ld_at = 0; cpu_at = 0; ld_n = 0; cpu_n = 0; gap_ok = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (o_ld_ack === 1'b1) begin
                ld_n++; if (ld_at == 0) ld_at = k; ld_req = 1'b0;
            end
            if (o_cpu_ack === 1'b1) begin
                cpu_n++; if (cpu_at == 0) cpu_at = k; cpu_req = 1'b0;
            end
            if (k == 5 && o_busy === 1'b0 && o_n_ce === 1'b1) gap_ok = 1'b1;
        end
        check("contend_ld_cycle", ld_at, 4);
        check("contend_cpu_cycle", cpu_at, 7);
        check("contend_ld_acks", ld_n, 1);
        check("contend_cpu_acks", cpu_n, 1);
        check("contend_idle_gap", {31'd0, gap_ok}, 32'd1);
        check("contend_rdata", {24'd0, o_rdata}, 32'h77);

        // prog gating, then release; prog raised mid-read must not abort it.
        prog = 1'b1; cpu_addr = 4'hF; cpu_we = 1'b0; cpu_req = 1'b1; gate_ok = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (o_cpu_ack !== 1'b0 || o_n_ce !== 1'b1 || o_n_we !== 1'b1 || o_busy !== 1'b0)
                gate_ok = 1'b0;
        end
        check("prog_gate", {31'd0, gate_ok}, 32'd1);
        prog = 1'b0; lat = 0;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            @(negedge clk);
            if (k == 1) prog = 1'b1;
            if (o_cpu_ack === 1'b1) begin
                lat = k; cpu_req = 1'b0;
            end
        end
        if (lat == 0) cpu_req = 1'b0;
        check("prog_release_latency", lat, 2);
        check("prog_release_rdata", {24'd0, o_rdata}, 32'hA5);
        prog = 1'b0;
        @(negedge clk);

        // WE_PULSE=4 instance: normal write, then reset during the pulse.
        sel = 1'b1;
        @(negedge clk);
        do_txn(1'b1, 1'b1, 4'h5, 8'h11, 1'b1, 8'h00, 4);
        ld_addr = 4'h5; ld_wdata = 8'hEE; ld_req = 1'b1; seen = 1'b0;
        for (int k = 1; k <= 10 && !seen; k++) begin
            @(negedge clk);
            if (o_n_we === 1'b0) seen = 1'b1;
        end
        check("mid_pulse_seen", {31'd0, seen}, 32'd1);
        @(negedge clk);
        rst = 1'b1; ld_req = 1'b0;
        @(negedge clk);
        check("abort_strobes", {30'd0, o_n_ce, o_n_we}, 32'h3);
        check("abort_ack_busy", {29'd0, o_ld_ack, o_cpu_ack, o_busy}, 32'd0);
        rst = 1'b0; quiet = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (o_ld_ack !== 1'b0 || o_busy !== 1'b0) quiet = 1'b0;
        end
        check("abort_no_ack", {31'd0, quiet}, 32'd1);
        do_txn(1'b0, 1'b0, 4'h5, 8'h00, 1'b0, 8'h00, 4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
